// File: rtl/tm1638_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tm1638_scheduler
//  Function : Periodic TM1638 frame sequencer feeding the spi_fifo input FIFO.
//             Each frame: data command, 16 fixed-address segment writes,
//             display control, key-scan read; then latches the 32-bit keys.
//  Revision : 1.0  initial release
// ============================================================================
module tm1638_scheduler #(
    parameter int REFRESH_CYCLES  = 250000,
    parameter int KEY_WAIT_CYCLES = 400,
    parameter int SEG_COUNT       = 16
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Enable,
    input  logic        i_Seg_We,
    input  logic [3:0]  i_Seg_Addr,
    input  logic [7:0]  i_Seg_Data,
    input  logic        i_Display_On,
    input  logic [2:0]  i_Brightness,
    input  logic        i_FIFO_Full,
    output logic        o_Data_Valid,
    output logic [17:0] o_Data,
    input  logic [31:0] i_Read_Data,
    output logic [31:0] o_Keys,
    output logic        o_Keys_Valid,
    output logic        o_Busy
);

    localparam int c_TIMER_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int c_WAIT_W  = (KEY_WAIT_CYCLES > 2) ? $clog2(KEY_WAIT_CYCLES) : 1;

    localparam logic [c_TIMER_W-1:0] c_TIMER_RELOAD = c_TIMER_W'(REFRESH_CYCLES - 1);
    // The KEY_LATCH cycle is part of the wait, so the counter covers the rest:
    // keys appear exactly KEY_WAIT_CYCLES after the key-read push cycle.
    localparam logic [c_WAIT_W-1:0]  c_WAIT_RELOAD  = c_WAIT_W'(KEY_WAIT_CYCLES - 2);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_DATA_CMD  = 3'd1;
    localparam logic [2:0] c_ST_SEG_WR    = 3'd2;
    localparam logic [2:0] c_ST_CTRL      = 3'd3;
    localparam logic [2:0] c_ST_KEY_CMD   = 3'd4;
    localparam logic [2:0] c_ST_KEY_WAIT  = 3'd5;
    localparam logic [2:0] c_ST_KEY_LATCH = 3'd6;

    logic [2:0]           r_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic [c_WAIT_W-1:0]  r_wait;
    logic [3:0]           r_seg_idx;
    logic [7:0]           r_seg_ram [SEG_COUNT];
    logic                 r_data_valid;
    logic [17:0]          r_data;
    logic [31:0]          r_keys;
    logic                 r_keys_valid;
    logic                 r_busy;

    logic w_frame_start;
    logic w_can_push;

    assign w_frame_start = (r_state == c_ST_IDLE) && (r_timer == '0) && i_Enable;
    // A push cycle is always followed by a gap cycle before FULL is looked at again.
    assign w_can_push    = !r_data_valid && !i_FIFO_Full;

    assign o_Data_Valid = r_data_valid;
    assign o_Data       = r_data;
    assign o_Keys       = r_keys;
    assign o_Keys_Valid = r_keys_valid;
    assign o_Busy       = r_busy;

    // Segment shadow RAM: cleared on reset, writable at any time.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int i = 0; i < SEG_COUNT; i++) begin
                r_seg_ram[i] <= 8'h00;
            end
        end else if (i_Seg_We) begin
            r_seg_ram[i_Seg_Addr] <= i_Seg_Data;
        end
    end

    // Refresh timer: reload on frame start, otherwise count down to zero.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_timer <= '0;
        end else if (w_frame_start) begin
            r_timer <= c_TIMER_RELOAD;
        end else if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
        end
    end

    // Frame sequencer with registered push, key and busy outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state      <= c_ST_IDLE;
            r_wait       <= '0;
            r_seg_idx    <= 4'd0;
            r_data_valid <= 1'b0;
            r_data       <= 18'd0;
            r_keys       <= 32'd0;
            r_keys_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_keys_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_frame_start) begin
                        r_state <= c_ST_DATA_CMD;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_DATA_CMD: begin
                    if (w_can_push) begin
                        r_data_valid <= 1'b1;
                        r_data       <= 18'h00044;
                        r_state      <= c_ST_SEG_WR;
                    end
                end
                c_ST_SEG_WR: begin
                    if (w_can_push) begin
                        r_data_valid <= 1'b1;
                        r_data       <= {2'b01, r_seg_ram[r_seg_idx], 4'hC, r_seg_idx};
                        r_seg_idx    <= r_seg_idx + 4'd1;
                        if (r_seg_idx == 4'hF) begin
                            r_state <= c_ST_CTRL;
                        end
                    end
                end
                c_ST_CTRL: begin
                    if (w_can_push) begin
                        r_data_valid <= 1'b1;
                        r_data       <= {2'b00, 8'h00, 4'h8, i_Display_On, i_Brightness};
                        r_state      <= c_ST_KEY_CMD;
                    end
                end
                c_ST_KEY_CMD: begin
                    if (w_can_push) begin
                        r_data_valid <= 1'b1;
                        r_data       <= 18'h20042;
                        r_wait       <= c_WAIT_RELOAD;
                        r_state      <= c_ST_KEY_WAIT;
                    end
                end
                c_ST_KEY_WAIT: begin
                    if (r_wait == '0) begin
                        r_state <= c_ST_KEY_LATCH;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                c_ST_KEY_LATCH: begin
                    r_keys       <= i_Read_Data;
                    r_keys_valid <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_busy    <= 1'b0;
                    r_seg_idx <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tm1638_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tm1638_scheduler
//  Function : Self-checking bench for tm1638_scheduler with a frame-level
//             reference model (expected word list, refresh and key timing).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tm1638_scheduler;

    localparam int c_REFRESH = 64;
    localparam int c_KWAIT   = 40;

    logic        clk;
    logic        r_rst, r_en, r_we, r_on, r_full;
    logic [3:0]  r_addr;
    logic [7:0]  r_sdata;
    logic [2:0]  r_br;
    logic [31:0] r_rd;
    logic        w_valid, w_keys_valid, w_busy;
    logic [17:0] w_data;
    logic [31:0] w_keys;

    tm1638_scheduler #(
        .REFRESH_CYCLES  (c_REFRESH),
        .KEY_WAIT_CYCLES (c_KWAIT),
        .SEG_COUNT       (16)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (r_rst),
        .i_Enable     (r_en),
        .i_Seg_We     (r_we),
        .i_Seg_Addr   (r_addr),
        .i_Seg_Data   (r_sdata),
        .i_Display_On (r_on),
        .i_Brightness (r_br),
        .i_FIFO_Full  (r_full),
        .o_Data_Valid (w_valid),
        .o_Data       (w_data),
        .i_Read_Data  (r_rd),
        .o_Keys       (w_keys),
        .o_Keys_Valid (w_keys_valid),
        .o_Busy       (w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference state: what the design saw at the most recent rising edge.
    logic [7:0]  model_ram [16];
    logic [7:0]  snap_ram  [16];
    logic        snap_rst, snap_en, snap_on, snap_full;
    logic [2:0]  snap_br;
    logic [31:0] snap_read;

    initial begin
        for (int i = 0; i < 16; i++) begin
            model_ram[i] = 8'h00;
            snap_ram[i]  = 8'h00;
        end
        snap_rst = 1'b1; snap_en = 1'b0; snap_on = 1'b0; snap_full = 1'b0;
        snap_br = 3'd0; snap_read = 32'd0;
        forever begin
            @(posedge clk);
            snap_ram  = model_ram;
            snap_rst  = r_rst;
            snap_en   = r_en;
            snap_on   = r_on;
            snap_br   = r_br;
            snap_full = r_full;
            snap_read = r_rd;
            if (r_rst) begin
                for (int i = 0; i < 16; i++) model_ram[i] = 8'h00;
            end else if (r_we) begin
                model_ram[r_addr] = r_sdata;
            end
        end
    end

    function automatic logic [17:0] exp_word(input int k);
        int w;
        if (k == 0)       w = 'h00044;
        else if (k == 17) w = 'h00080 + (snap_on ? 8 : 0) + int'(snap_br);
        else if (k == 18) w = 'h20042;
        else              w = 'h10000 + (int'(snap_ram[k-1]) << 8) + 'hC0 + (k - 1);
        return w[17:0];
    endfunction

    // Frame-level model and monitor, evaluated on the falling edge.
    int          cyc = 0;
    int          idx = 0;
    int          pushes = 0;
    int          frames_done = 0;
    int          last_start = -1000;
    int          last_push = -100;
    int          key_due = -1;
    bit          model_idle = 1'b1;
    logic [17:0] frame_words [19];
    logic [17:0] last_frame  [19];

    initial begin
        bit exp_busy, exp_kv;
        for (int i = 0; i < 19; i++) begin
            frame_words[i] = '0;
            last_frame[i]  = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (snap_rst) begin
                chk("rst_valid", w_valid, 0);
                chk("rst_busy", w_busy, 0);
                chk("rst_keys_valid", w_keys_valid, 0);
                chk("rst_keys", w_keys, 0);
                chk("rst_data", w_data, 0);
                idx = 0; model_idle = 1'b1; last_start = -1000;
                key_due = -1; last_push = -100;
            end else begin
                if (w_valid) begin
                    chk("push_while_full", snap_full, 0);
                    chk("push_gap", (cyc - last_push) >= 2, 1);
                    chk("push_in_frame", (!model_idle && idx < 19), 1);
                    if (idx < 19) begin
                        chk($sformatf("word%0d", idx), w_data, exp_word(idx));
                        frame_words[idx] = w_data;
                    end
                    idx++; pushes++; last_push = cyc;
                    if (idx == 19) key_due = cyc + c_KWAIT;
                end
                exp_kv = (cyc == key_due);
                if (model_idle) begin
                    exp_busy = snap_en && ((cyc - last_start) >= c_REFRESH);
                    if (exp_busy) begin
                        model_idle = 1'b0; last_start = cyc; idx = 0;
                    end
                end else if (exp_kv) begin
                    chk("keys", w_keys, snap_read);
                    chk("frame_len", idx, 19);
                    model_idle = 1'b1; exp_busy = 1'b0; key_due = -1;
                    last_frame = frame_words;
                    frames_done++;
                end else begin
                    exp_busy = 1'b1;
                end
                chk("busy", w_busy, exp_busy);
                chk("keys_valid", w_keys_valid, exp_kv);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int target = frames_done + n;
        int k = 0;
        while (frames_done < target && k < budget) begin
            tick();
            k++;
        end
        chk("frame_timeout", frames_done >= target, 1);
    endtask

    task automatic wait_seg(input int n, input int budget);
        int k = 0;
        while (!(idx == n && !model_idle) && k < budget) begin
            tick();
            k++;
        end
        chk("seg_wait_timeout", (idx == n && !model_idle), 1);
    endtask

    initial begin
        int p0, f0;
        r_rst = 1'b1; r_en = 1'b0; r_we = 1'b0; r_addr = 4'd0; r_sdata = 8'd0;
        r_on = 1'b0; r_br = 3'd0; r_full = 1'b0; r_rd = 32'h12345678;
        repeat (3) tick();
        r_rst = 1'b0; r_en = 1'b1;

        // First frame after reset with an all-zero RAM.
        wait_frames(1, 300);
        chk("f1_w0", last_frame[0], 18'h00044);
        chk("f1_w1", last_frame[1], 18'h100C0);
        chk("f1_w16", last_frame[16], 18'h100CF);
        chk("f1_w17", last_frame[17], 18'h00080);
        chk("f1_w18", last_frame[18], 18'h20042);
        chk("f1_keys", w_keys, 32'h12345678);

        // RAM[5] and display control changes appear in the running frame.
        r_we = 1'b1; r_addr = 4'd5; r_sdata = 8'hA5; r_on = 1'b1; r_br = 3'd7;
        tick();
        r_we = 1'b0;
        wait_frames(1, 300);
        chk("f2_w6", last_frame[6], 18'h1A5C5);
        chk("f2_w17", last_frame[17], 18'h0008F);

        // Randomised writes, control, back-pressure and read data.
        for (int i = 0; i < 400; i++) begin
            r_we    = ($urandom_range(0, 3) == 0);
            r_addr  = 4'($urandom_range(0, 15));
            r_sdata = 8'($urandom);
            r_full  = ($urandom_range(0, 3) == 0);
            r_rd    = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                r_on = 1'($urandom);
                r_br = 3'($urandom);
            end
            tick();
        end
        r_we = 1'b0; r_full = 1'b0; r_rd = 32'hCAFE0001;
        wait_frames(2, 1000);

        // FIFO full for 50 cycles with segment n=7 pending.
        wait_seg(8, 300);
        r_full = 1'b1;
        p0 = pushes;
        repeat (50) tick();
        chk("stall_no_push", pushes, p0);
        chk("stall_busy", w_busy, 1);
        r_full = 1'b0;
        wait_frames(1, 300);
        chk("stall_w8_addr", last_frame[8][7:0], 8'hC7);
        chk("stall_w9_addr", last_frame[9][7:0], 8'hC8);

        // Enable dropped mid-frame: frame completes, nothing new starts.
        wait_seg(10, 300);
        r_en = 1'b0;
        f0 = frames_done;
        wait_frames(1, 300);
        repeat (150) tick();
        chk("noen_frames", frames_done, f0 + 1);
        chk("noen_busy", w_busy, 0);
        r_en = 1'b1;
        wait_frames(1, 300);

        // Reset during SEG_WR clears RAM and restarts from DATA_CMD.
        r_we = 1'b1; r_addr = 4'd3; r_sdata = 8'h3C;
        tick();
        r_we = 1'b0;
        wait_seg(5, 300);
        r_rst = 1'b1;
        tick();
        chk("midrst_valid", w_valid, 0);
        chk("midrst_busy", w_busy, 0);
        r_rst = 1'b0;
        wait_frames(1, 300);
        chk("postrst_w0", last_frame[0], 18'h00044);
        chk("postrst_w4", last_frame[4], 18'h100C3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
